// File: rtl/vram_arb_pkg.sv
// Shared types for the video RAM arbiter: response-owner encoding and slot phases.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam logic SLOT_VID = 1'b0;
    localparam logic SLOT_CPU = 1'b1;

endpackage

// File: rtl/vram_arb_resp_pipe.sv
// Two-stage owner shift register tracking in-flight RAM accesses, and steering of the
// RAM read data to whichever requester owns the access completing this cycle.
module vram_arb_resp_pipe
    import vram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  owner_t            i_owner,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata
);

    owner_t r_own_s1;
    owner_t r_own_s2;

    // Reset flushes both stages so aborted accesses never produce a response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_own_s1 <= OWN_NONE;
            r_own_s2 <= OWN_NONE;
        end else begin
            r_own_s1 <= i_owner;
            r_own_s2 <= r_own_s1;
        end
    end

    assign o_cpu_ack    = (r_own_s2 == OWN_CPU);
    assign o_vid_rvalid = (r_own_s2 == OWN_VID);
    assign o_cpu_rdata  = o_cpu_ack ? i_mem_rdata : '0;
    assign o_vid_rdata  = o_vid_rvalid ? i_mem_rdata : '0;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: even cycles favour scanout, odd cycles favour the CPU,
// idle slots are lent to the other side, and the CPU wins every slot during blanking.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              vid_blank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              r_phase;
    logic              r_cpu_busy;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic   w_cpu_busy;
    logic   w_cpu_elig;
    logic   w_cpu_gnt;
    logic   w_vid_gnt;
    owner_t w_owner;

    // Busy drops in the ack cycle so a back-to-back request can be granted right away.
    assign w_cpu_busy = r_cpu_busy && !cpu_ack;
    assign w_cpu_elig = cpu_req && !w_cpu_busy;

    always_comb begin
        w_owner = OWN_NONE;
        if (reset_n) begin
            if (vid_blank || (r_phase == SLOT_CPU)) begin
                if (w_cpu_elig) begin
                    w_owner = OWN_CPU;
                end else if (vid_req) begin
                    w_owner = OWN_VID;
                end
            end else begin
                if (vid_req) begin
                    w_owner = OWN_VID;
                end else if (w_cpu_elig) begin
                    w_owner = OWN_CPU;
                end
            end
        end
    end

    assign w_cpu_gnt = (w_owner == OWN_CPU);
    assign w_vid_gnt = (w_owner == OWN_VID);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase     <= SLOT_VID;
            r_cpu_busy  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_phase    <= ~r_phase;
            r_cpu_busy <= w_cpu_gnt || w_cpu_busy;
            r_mem_en   <= w_cpu_gnt || w_vid_gnt;
            r_mem_we   <= w_cpu_gnt && cpu_we;
            if (w_cpu_gnt) begin
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end else if (w_vid_gnt) begin
                r_mem_addr <= vid_addr;
            end
        end
    end

    vram_arb_resp_pipe #(
        .DATA_W (DATA_W)
    ) u_resp_pipe (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_owner      (w_owner),
        .i_mem_rdata  (mem_rdata),
        .o_cpu_ack    (cpu_ack),
        .o_cpu_rdata  (cpu_rdata),
        .o_vid_rvalid (vid_rvalid),
        .o_vid_rdata  (vid_rdata)
    );

    assign vid_gnt   = w_vid_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural RAM plus a transaction-level model of the slot
// rules predicts every grant, response and RAM-side access cycle by cycle.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n   = 1'b0;
    logic          cpu_req   = 1'b0;
    logic          cpu_we    = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req   = 1'b0;
    logic [AW-1:0] vid_addr  = '0;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          vid_blank = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vram_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .vid_blank  (vid_blank),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        logic [DW-1:0] lo;
        lo = a[DW-1:0];
        return (lo * 8'd37) ^ a[AW-1:AW-DW];
    endfunction

    // Behavioural single-port RAM, read data one cycle after the enable.
    logic [DW-1:0] env_ram [logic [AW-1:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_ram[mem_addr] = mem_wdata;
            else mem_rdata <= env_ram.exists(mem_addr) ? env_ram[mem_addr] : init_val(mem_addr);
        end
    end

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } cpu_txn_t;

    typedef struct {
        longint        due;
        bit            is_cpu;
        bit            we;
        logic [DW-1:0] data;
    } resp_t;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    longint        g = 0;
    int            m_cnt = 0;
    longint        m_last_cpu = -10;
    resp_t         m_resp[$];
    logic [DW-1:0] m_ram [logic [AW-1:0]];
    bit            m_en = 1'b0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_cpu_acks = 0;

    // Stimulus state
    cpu_txn_t      cpu_q[$];
    cpu_txn_t      cpu_cur = '{we: 1'b0, addr: '0, wdata: '0, gap: 0};
    bit            cpu_have = 1'b0;
    bit            cpu_granted = 1'b0;
    int            cpu_wait = 0;
    int            cpu_issued = 0;
    int            cpu_lost = 0;
    int            vid_left = 0;
    bit            vid_rand = 1'b0;
    int            vid_ptr = 0;
    logic [AW-1:0] vid_mask = '1;
    int            blank_mode = 0;
    int            rst_left = 0;
    bit            zero_chk = 1'b0;
    bit            start_odd = 1'b0;

    // Observed DUT activity
    int            dut_cpu_acks = 0;
    int            dut_vid_rv = 0;
    logic [DW-1:0] last_cpu_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, g);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(logic [AW-1:0] a);
        return m_ram.exists(a) ? m_ram[a] : init_val(a);
    endfunction

    task automatic drive();
        bit ack_now;
        bit hold;
        ack_now = (m_resp.size() > 0) && (m_resp[0].due == g) && m_resp[0].is_cpu;
        reset_n = (rst_left == 0);
        if (rst_left > 0) rst_left--;
        hold = start_odd && (m_cnt % 2 == 0);
        if (ack_now) begin
            cpu_have    = 1'b0;
            cpu_granted = 1'b0;
            cpu_wait    = cpu_cur.gap;
        end
        if (!cpu_have && !hold) begin
            if (cpu_wait > 0) begin
                cpu_wait--;
            end else if (cpu_q.size() > 0) begin
                cpu_cur  = cpu_q.pop_front();
                cpu_have = 1'b1;
                cpu_issued++;
            end
        end
        cpu_req   = cpu_have;
        cpu_we    = cpu_cur.we;
        cpu_addr  = cpu_cur.addr;
        cpu_wdata = cpu_cur.wdata;
        vid_req   = (vid_left != 0) && !hold && (!vid_rand || ($urandom_range(0, 1) == 1));
        vid_addr  = AW'(vid_ptr) & vid_mask;
        vid_blank = (blank_mode == 2) ? 1'($urandom_range(0, 1)) : (blank_mode == 1);
        if (start_odd && !hold) start_odd = 1'b0;
    endtask

    task automatic step();
        bit            rst;
        bit            phase;
        bit            elig;
        bit            g_vid;
        bit            g_cpu;
        bit            e_ack;
        bit            e_rv;
        bit            e_rd_chk;
        logic [DW-1:0] e_data;
        resp_t         r;
        rst      = !reset_n;
        phase    = m_cnt[0];
        e_ack    = 1'b0;
        e_rv     = 1'b0;
        e_rd_chk = 1'b0;
        e_data   = '0;
        if (m_resp.size() > 0 && m_resp[0].due == g) begin
            r = m_resp.pop_front();
            if (r.is_cpu) begin
                e_ack    = 1'b1;
                e_rd_chk = !r.we;
            end else begin
                e_rv = 1'b1;
            end
            e_data = r.data;
        end
        // A CPU granted last cycle is still busy; it frees up in its ack cycle.
        elig  = cpu_req && (g - m_last_cpu >= 2);
        g_vid = 1'b0;
        g_cpu = 1'b0;
        if (!rst) begin
            if (vid_blank || phase) begin
                if (elig) g_cpu = 1'b1;
                else if (vid_req) g_vid = 1'b1;
            end else begin
                if (vid_req) g_vid = 1'b1;
                else if (elig) g_cpu = 1'b1;
            end
        end

        check_eq("vid_gnt", vid_gnt, g_vid);
        check_eq("cpu_ack", cpu_ack, e_ack);
        check_eq("vid_rvalid", vid_rvalid, e_rv);
        if (e_rd_chk) check_eq("cpu_rdata", cpu_rdata, e_data);
        if (e_rv) check_eq("vid_rdata", vid_rdata, e_data);
        check_eq("mem_en", mem_en, m_en);
        check_eq("mem_we", mem_we, m_we);
        if (m_en) check_eq("mem_addr", mem_addr, m_addr);
        if (m_en && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        if (rst && zero_chk) begin
            check_eq("rst_mem_addr", mem_addr, 0);
            check_eq("rst_mem_wdata", mem_wdata, 0);
            check_eq("rst_cpu_rdata", cpu_rdata, 0);
            check_eq("rst_vid_rdata", vid_rdata, 0);
        end
        if (cpu_ack) begin
            dut_cpu_acks++;
            last_cpu_rd = cpu_rdata;
        end
        if (vid_rvalid) dut_vid_rv++;
        if (e_ack) m_cpu_acks++;

        m_en = g_vid || g_cpu;
        m_we = g_cpu && cpu_we;
        if (g_cpu) begin
            m_addr  = cpu_addr;
            m_wdata = cpu_wdata;
            m_resp.push_back('{due: g + 2, is_cpu: 1'b1, we: cpu_we, data: m_rd(cpu_addr)});
            if (cpu_we) m_ram[cpu_addr] = cpu_wdata;
            m_last_cpu  = g;
            cpu_granted = 1'b1;
        end else if (g_vid) begin
            m_addr = vid_addr;
            m_resp.push_back('{due: g + 2, is_cpu: 1'b0, we: 1'b0, data: m_rd(vid_addr)});
            vid_ptr++;
            if (vid_left > 0) vid_left--;
        end
        if (rst) begin
            m_en       = 1'b0;
            m_we       = 1'b0;
            m_cnt      = 0;
            m_last_cpu = g - 1;
            while (m_resp.size() > 0) begin
                r = m_resp.pop_back();
                if (r.is_cpu) begin
                    cpu_have    = 1'b0;
                    cpu_granted = 1'b0;
                    cpu_lost++;
                end
            end
        end else begin
            m_cnt++;
        end
        g++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_cpu_idle(input int bound);
        int k;
        k = 0;
        while ((cpu_q.size() > 0 || cpu_have) && k < bound) begin
            cycle();
            k++;
        end
        check_eq("cpu_pending", cpu_q.size() + int'(cpu_have), 0);
        run(3);
    endtask

    initial begin
        int       a0;
        int       v0;
        bit       vg0;
        cpu_txn_t t;

        // Reset with both sides requesting: everything quiet, then video first.
        zero_chk = 1'b1;
        vid_left = 4;
        cpu_q.push_back('{we: 1'b0, addr: 15'h0100, wdata: 8'h00, gap: 1});
        rst_left = 4;
        run(4);
        zero_chk = 1'b0;
        cycle();
        check_eq("first_gnt_vid", vid_gnt, 1);
        wait_cpu_idle(20);
        run(4);

        // Streaming video 0x000..0x00F with no CPU traffic.
        vid_ptr  = 0;
        vid_left = 16;
        v0       = dut_vid_rv;
        run(20);
        check_eq("vid_stream_cnt", dut_vid_rv - v0, 16);

        // Continuous video with a CPU write then read of 0x1234.
        vid_left = -1;
        a0       = dut_cpu_acks;
        cpu_q.push_back('{we: 1'b1, addr: 15'h1234, wdata: 8'h55, gap: 1});
        cpu_q.push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00, gap: 1});
        wait_cpu_idle(30);
        check_eq("wr_rd_acks", dut_cpu_acks - a0, 2);
        check_eq("rd_back_55", last_cpu_rd, 8'h55);
        vid_left = 0;
        run(4);

        // Both raise together in a CPU slot: CPU first, video the next cycle.
        start_odd = 1'b1;
        vid_left  = 1;
        cpu_q.push_back('{we: 1'b0, addr: 15'h0020, wdata: 8'h00, gap: 1});
        for (int i = 0; i < 4 && start_odd; i++) cycle();
        vg0 = vid_gnt;
        check_eq("p1_vid_waits", vg0, 0);
        cycle();
        check_eq("p1_vid_next", vid_gnt, 1);
        check_eq("p1_cpu_on_mem", mem_addr, 15'h0020);
        wait_cpu_idle(10);

        // Blanking with both requesting back-to-back: every slot used, none lost.
        blank_mode = 1;
        vid_left   = -1;
        for (int i = 0; i < 30; i++) begin
            t = '{we: 1'b0, addr: AW'($urandom_range(0, 255)), wdata: 8'h00, gap: 0};
            cpu_q.push_back(t);
        end
        run(4);
        a0 = dut_cpu_acks;
        v0 = dut_vid_rv;
        begin
            int ma;
            ma = m_cpu_acks;
            run(24);
            check_eq("blank_cpu_cnt", dut_cpu_acks - a0, m_cpu_acks - ma);
        end
        check_eq("blank_slots_full", (dut_cpu_acks - a0) + (dut_vid_rv - v0), 24);
        vid_left   = 0;
        blank_mode = 0;
        wait_cpu_idle(100);

        // Reset right after a CPU read grant aborts it; a fresh read then works.
        cpu_q.push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00, gap: 1});
        for (int i = 0; i < 10 && !cpu_granted; i++) cycle();
        check_eq("rst_rd_granted", cpu_granted, 1);
        a0       = dut_cpu_acks;
        rst_left = 1;
        run(4);
        check_eq("rst_no_ack", dut_cpu_acks - a0, 0);
        cpu_q.push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00, gap: 1});
        wait_cpu_idle(10);
        check_eq("post_rst_ack", dut_cpu_acks - a0, 1);
        check_eq("post_rst_data", last_cpu_rd, 8'h55);

        // Randomised mix over a small shared window, with a mid-run reset.
        blank_mode = 2;
        vid_rand   = 1'b1;
        vid_left   = -1;
        vid_mask   = 15'h003f;
        for (int i = 0; i < 60; i++) begin
            t.we    = 1'($urandom_range(0, 1));
            t.addr  = AW'($urandom_range(0, 63));
            t.wdata = DW'($urandom);
            t.gap   = $urandom_range(0, 3);
            cpu_q.push_back(t);
        end
        run(200);
        rst_left = 1;
        run(200);
        vid_left = 0;
        wait_cpu_idle(600);
        check_eq("cpu_no_loss", dut_cpu_acks + cpu_lost, cpu_issued);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
